// File: rtl/riscv_i32_trace_buffer.sv
// Compressed retired-instruction tracer: START/BRANCH/COUNT/OVERFLOW records queued in a FIFO.
// Define RISCV_I32_TRACE_REGWRITE_EN to also emit REGWRITE records for rd writes.
module riscv_i32_trace_buffer #(
  parameter int LOG_DEPTH   = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clk_enable,
  input  logic                   trace_enable,
  input  logic                   trace_clear,
  input  logic                   trace_valid,
  input  logic [31:0]            pc,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  input  logic                   rd_written,
  input  logic [4:0]             rd,
  input  logic [31:0]            result,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [2:0]             rec_type,
  output logic [31:0]            rec_address,
  output logic [31:0]            rec_data,
  output logic [COUNT_WIDTH-1:0] rec_count,
  output logic [LOG_DEPTH:0]     fill_level,
  output logic                   overflow
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0]     FULL_LEVEL = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = '1;

  localparam logic [2:0] T_START    = 3'd0;
  localparam logic [2:0] T_BRANCH   = 3'd1;
  localparam logic [2:0] T_OVERFLOW = 3'd2;
  localparam logic [2:0] T_COUNT    = 3'd3;
`ifdef RISCV_I32_TRACE_REGWRITE_EN
  localparam logic [2:0] T_REGWRITE = 3'd4;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  typedef struct packed {
    logic [2:0]             typ;
    logic [31:0]            addr;
    logic [31:0]            data;
    logic [COUNT_WIDTH-1:0] cnt;
  } rec_t;

  state_t                 r_state;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [COUNT_WIDTH-1:0] r_drop;
  logic                   r_overflow;
  logic [LOG_DEPTH-1:0]   r_wr_ptr;
  logic [LOG_DEPTH-1:0]   r_rd_ptr;
  logic [LOG_DEPTH:0]     r_fill;
  rec_t                   r_mem [DEPTH];

  state_t                 w_state_next;
  logic [COUNT_WIDTH-1:0] w_cnt_next;
  logic [COUNT_WIDTH-1:0] w_cnt_inc;
  logic                   w_gen;
  rec_t                   w_gen_rec;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_drop;
  logic [COUNT_WIDTH-1:0] w_drop_sum;
  logic [COUNT_WIDTH-1:0] w_drop_next;
  logic                   w_push;
  rec_t                   w_push_rec;
  rec_t                   w_head;

`ifndef RISCV_I32_TRACE_REGWRITE_EN
  logic w_unused_regwrite;
  assign w_unused_regwrite = ^{rd_written, rd, result};
`endif

  assign w_cnt_inc = r_cnt + 1'b1;

  // Record generation: at most one candidate record per cycle.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_gen        = 1'b0;
    w_gen_rec    = '0;
    case (r_state)
      S_IDLE: begin
        if (trace_enable && trace_valid) begin
          w_gen          = 1'b1;
          w_gen_rec.typ  = T_START;
          w_gen_rec.addr = pc;
          w_state_next   = S_RUN;
          w_cnt_next     = '0;
        end
      end
      S_RUN: begin
        if (!trace_enable) begin
          w_state_next = S_IDLE;
        end else if (trace_valid) begin
          if (branch_taken) begin
            w_gen          = 1'b1;
            w_gen_rec.typ  = T_BRANCH;
            w_gen_rec.addr = pc;
            w_gen_rec.data = branch_target;
            w_gen_rec.cnt  = w_cnt_inc;
            w_cnt_next     = '0;
`ifdef RISCV_I32_TRACE_REGWRITE_EN
          end else if (rd_written && (rd != 5'd0)) begin
            w_gen          = 1'b1;
            w_gen_rec.typ  = T_REGWRITE;
            w_gen_rec.addr = pc;
            w_gen_rec.data = result;
            w_gen_rec.cnt  = COUNT_WIDTH'(rd);
            // A COUNT due now is postponed: the counter parks at max-1.
            w_cnt_next     = (w_cnt_inc == CNT_MAX) ? r_cnt : w_cnt_inc;
`endif
          end else if (w_cnt_inc == CNT_MAX) begin
            w_gen          = 1'b1;
            w_gen_rec.typ  = T_COUNT;
            w_gen_rec.addr = pc;
            w_gen_rec.cnt  = CNT_MAX;
            w_cnt_next     = '0;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_full = (r_fill == FULL_LEVEL);
  assign w_pop  = (r_fill != '0) && rec_ready;

  // Once anything is lost, later records are lost too until the OVERFLOW marker lands.
  always_comb begin
    w_drop      = w_gen && (w_full || (r_drop != '0));
    w_drop_sum  = (w_drop && (r_drop != CNT_MAX)) ? r_drop + 1'b1 : r_drop;
    w_drop_next = w_drop_sum;
    w_push      = 1'b0;
    w_push_rec  = w_gen_rec;
    if (!w_full && (r_drop != '0)) begin
      w_push          = 1'b1;
      w_push_rec      = '0;
      w_push_rec.typ  = T_OVERFLOW;
      w_push_rec.cnt  = w_drop_sum;
      w_drop_next     = '0;
    end else if (w_gen && !w_drop) begin
      w_push = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_drop     <= '0;
      r_overflow <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
    end else if (clk_enable) begin
      if (trace_clear) begin
        r_state    <= S_IDLE;
        r_cnt      <= '0;
        r_drop     <= '0;
        r_overflow <= 1'b0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_fill     <= '0;
      end else begin
        r_state    <= w_state_next;
        r_cnt      <= w_cnt_next;
        r_drop     <= w_drop_next;
        r_overflow <= r_overflow | w_drop;
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_fill <= r_fill + 1'b1;
          2'b01:   r_fill <= r_fill - 1'b1;
          default: r_fill <= r_fill;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clk_enable && !trace_clear && w_push) begin
      r_mem[r_wr_ptr] <= w_push_rec;
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign rec_valid   = (r_fill != '0);
  assign rec_type    = w_head.typ;
  assign rec_address = w_head.addr;
  assign rec_data    = w_head.data;
  assign rec_count   = w_head.cnt;
  assign fill_level  = r_fill;
  assign overflow    = r_overflow;

endmodule
